// File: rtl/minimips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// minimips_ctrl_pkg
//
// Shared definitions for the MiniMIPS multi-cycle main controller:
//   - opcode values of IR[15:12]
//   - ALUop encodings (shared with Alu_Control)
//   - datapath select encodings (pc_source, alu_src_a, alu_src_b, iord,
//     reg_dst, mem_to_reg)
//   - the 4-bit controller state enumeration
//   - the packed bundle of controller outputs
//   - small opcode-decoding helpers used by the controller
// ----------------------------------------------------------------------------
package minimips_ctrl_pkg;

  localparam int OPCODE_W = 4;
  localparam int ALU_OP_W = 3;

  // Opcodes (IR[15:12]); 1001-1111 are undefined.
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_J     = 4'b1000;

  // ALUop encodings understood by Alu_Control.
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_FUNC = 3'b111;

  // PC input mux.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;  // PC + 1 straight from the ALU
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;  // branch target held in ALUOut
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump target

  // ALU operand muxes.
  localparam logic       SRC_A_PC     = 1'b0;
  localparam logic       SRC_A_REG    = 1'b1;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_ONE    = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  // Memory address, register destination and write-back data muxes.
  localparam logic IORD_PC        = 1'b0;
  localparam logic IORD_ALUOUT    = 1'b1;
  localparam logic REG_DST_RT     = 1'b0;
  localparam logic REG_DST_RD     = 1'b1;
  localparam logic MEM_TO_REG_ALU = 1'b0;
  localparam logic MEM_TO_REG_MDR = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_I_EXEC    = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  // Every controller output in one bundle so a single '0 gives the
  // all-inactive default.
  typedef struct packed {
    logic                mem_req;
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_source;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                illegal_op;
    logic                retired;
  } ctrl_out_t;

  // State reached from DECODE; undefined opcodes return straight to FETCH.
  function automatic state_e decode_target(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE:                return S_R_EXEC;
      OP_ADDI, OP_ANDI, OP_ORI: return S_I_EXEC;
      OP_LW, OP_SW:            return S_MEM_ADDR;
      OP_BEQ, OP_BNE:          return S_BRANCH;
      OP_J:                    return S_JUMP;
      default:                 return S_FETCH;
    endcase
  endfunction

  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
    return op <= OP_J;
  endfunction

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [ALU_OP_W-1:0] i_type_alu_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// ----------------------------------------------------------------------------
// main_control_fsm_if
//
// Bundle between the main controller and the MiniMIPS datapath / memory.
//   master : the controller (drives selects and enables, reads status)
//   slave  : the datapath side (supplies opcode, alu_zero, mem_ready)
//
// Status into the controller:
//   opcode[3:0]   IR[15:12], valid from DECODE onward
//   alu_zero      ALU zero flag
//   mem_ready     memory completes the current access this cycle
// Controls out of the controller:
//   mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_source[1:0],
//   alu_src_a, alu_src_b[1:0], alu_op[2:0], reg_dst, mem_to_reg, reg_write,
//   illegal_op, retired
// ----------------------------------------------------------------------------
interface main_control_fsm_if;
  import minimips_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero;
  logic                mem_ready;

  logic                mem_req;
  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_source;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                illegal_op;
  logic                retired;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal_op, retired
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal_op, retired
  );

endinterface

// File: rtl/main_control_fsm.sv
// ----------------------------------------------------------------------------
// main_control_fsm
//
// Multi-cycle main controller for MiniMIPS. Walks one instruction at a time
// through FETCH, DECODE, execute, memory and write-back, driving every
// datapath select/enable and the ALUop for Alu_Control.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high; forces IDLE (all outputs 0)
//   ctrl   master side of main_control_fsm_if (opcode, alu_zero, mem_ready
//          in; all controls out)
//
// Outputs are decoded from the state alone, except ir_write/pc_write in
// FETCH (gated by mem_ready), pc_write in BRANCH (gated by alu_zero),
// retired in MEM_WRITE (gated by mem_ready), and illegal_op / alu_op, which
// read the opcode the IR already holds. The opcode is never copied into
// this block: the IR is the only holder of it.
// ----------------------------------------------------------------------------
module main_control_fsm
  import minimips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  main_control_fsm_if.master  ctrl
);

  state_e    state_q;
  state_e    state_d;
  ctrl_out_t out;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: flops use non-blocking (<=) so every register samples pre-edge
  // values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first give every path an assignment, so no latch is
    // inferred and every output not named in a state reads 0.
    state_d = state_q;
    out     = '0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // Read the instruction at PC while the ALU forms PC + 1. IR and PC load
      // together on the cycle the memory completes.
      S_FETCH: begin
        out.mem_req   = 1'b1;
        out.mem_read  = 1'b1;
        out.iord      = IORD_PC;
        out.alu_src_a = SRC_A_PC;
        out.alu_src_b = SRC_B_ONE;
        out.alu_op    = ALU_ADD;
        out.pc_source = PC_SRC_ALU;
        out.ir_write  = ctrl.mem_ready;
        out.pc_write  = ctrl.mem_ready;
        if (ctrl.mem_ready) begin
          state_d = S_DECODE;
        end
      end

      // PC already points past this instruction, so PC + offset computed here
      // is the branch target; it is parked in ALUOut for BRANCH.
      S_DECODE: begin
        out.alu_src_a  = SRC_A_PC;
        out.alu_src_b  = SRC_B_BRANCH;
        out.alu_op     = ALU_ADD;
        out.illegal_op = ~is_legal_opcode(ctrl.opcode);
        state_d        = decode_target(ctrl.opcode);
      end

      S_R_EXEC: begin
        out.alu_src_a = SRC_A_REG;
        out.alu_src_b = SRC_B_REG;
        out.alu_op    = ALU_FUNC;
        state_d       = S_R_WB;
      end

      S_R_WB: begin
        out.reg_dst    = REG_DST_RD;
        out.mem_to_reg = MEM_TO_REG_ALU;
        out.reg_write  = 1'b1;
        out.retired    = 1'b1;
        state_d        = S_FETCH;
      end

      S_I_EXEC: begin
        out.alu_src_a = SRC_A_REG;
        out.alu_src_b = SRC_B_IMM;
        out.alu_op    = i_type_alu_op(ctrl.opcode);
        state_d       = S_I_WB;
      end

      S_I_WB: begin
        out.reg_dst    = REG_DST_RT;
        out.mem_to_reg = MEM_TO_REG_ALU;
        out.reg_write  = 1'b1;
        out.retired    = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_ADDR: begin
        out.alu_src_a = SRC_A_REG;
        out.alu_src_b = SRC_B_IMM;
        out.alu_op    = ALU_ADD;
        state_d       = (ctrl.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        out.mem_req  = 1'b1;
        out.mem_read = 1'b1;
        out.iord     = IORD_ALUOUT;
        if (ctrl.mem_ready) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        out.reg_dst    = REG_DST_RT;
        out.mem_to_reg = MEM_TO_REG_MDR;
        out.reg_write  = 1'b1;
        out.retired    = 1'b1;
        state_d        = S_FETCH;
      end

      // A store has nothing left to do once memory accepts it, so it retires
      // in its completing cycle.
      S_MEM_WRITE: begin
        out.mem_req   = 1'b1;
        out.mem_write = 1'b1;
        out.iord      = IORD_ALUOUT;
        out.retired   = ctrl.mem_ready;
        if (ctrl.mem_ready) begin
          state_d = S_FETCH;
        end
      end

      // The subtract only produces alu_zero; the target comes from ALUOut.
      S_BRANCH: begin
        out.alu_src_a = SRC_A_REG;
        out.alu_src_b = SRC_B_REG;
        out.alu_op    = ALU_SUB;
        out.pc_source = PC_SRC_ALUOUT;
        out.pc_write  = (ctrl.opcode == OP_BNE) ? ~ctrl.alu_zero : ctrl.alu_zero;
        out.retired   = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        out.pc_source = PC_SRC_JUMP;
        out.pc_write  = 1'b1;
        out.retired   = 1'b1;
        state_d       = S_FETCH;
      end

      // Unused encodings recover through IDLE with everything inactive.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Drive the bus
  // --------------------------------------------------------------------------
  assign ctrl.mem_req    = out.mem_req;
  assign ctrl.mem_read   = out.mem_read;
  assign ctrl.mem_write  = out.mem_write;
  assign ctrl.iord       = out.iord;
  assign ctrl.ir_write   = out.ir_write;
  assign ctrl.pc_write   = out.pc_write;
  assign ctrl.pc_source  = out.pc_source;
  assign ctrl.alu_src_a  = out.alu_src_a;
  assign ctrl.alu_src_b  = out.alu_src_b;
  assign ctrl.alu_op     = out.alu_op;
  assign ctrl.reg_dst    = out.reg_dst;
  assign ctrl.mem_to_reg = out.mem_to_reg;
  assign ctrl.reg_write  = out.reg_write;
  assign ctrl.illegal_op = out.illegal_op;
  assign ctrl.retired    = out.retired;

endmodule

// File: tb/tb_main_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_main_control_fsm
//
// Each instruction is described as (opcode, fetch wait cycles, memory wait
// cycles, alu_zero) and expanded into a per-cycle plan of inputs and the
// control word the datapath should see in that cycle. A driver applies the
// inputs and pushes the expected word into a scoreboard queue; a monitor on
// the falling edge pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_main_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       retired;
  } obs_t;

  typedef struct {
    logic [3:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    obs_t       exp;
    string      tag;
  } step_t;

  logic clk;
  logic reset;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  step_t plan[$];
  step_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic obs_t sample();
    obs_t o;
    o.mem_req    = bus.mem_req;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.iord       = bus.iord;
    o.ir_write   = bus.ir_write;
    o.pc_write   = bus.pc_write;
    o.pc_source  = bus.pc_source;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.illegal_op = bus.illegal_op;
    o.retired    = bus.retired;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %05h expected %05h", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: instruction -> per-cycle plan
  // --------------------------------------------------------------------------
  task automatic add_step(input logic [3:0] op, input logic az, input logic rdy,
                          input obs_t o, input string tag);
    step_t s;
    s.opcode    = op;
    s.alu_zero  = az;
    s.mem_ready = rdy;
    s.exp       = o;
    s.tag       = tag;
    plan.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic az);
    obs_t o;
    // Instruction fetch: the opcode bus still shows stale IR contents.
    for (int i = 0; i <= fw; i++) begin
      o = '0;
      o.mem_req   = 1'b1;
      o.mem_read  = 1'b1;
      o.alu_src_b = 2'b01;
      o.ir_write  = (i == fw);
      o.pc_write  = (i == fw);
      add_step(4'($urandom_range(0, 15)), rbit(), i == fw, o, "fetch");
    end
    o = '0;
    o.alu_src_b  = 2'b11;
    o.illegal_op = (op > 4'd8);
    add_step(op, rbit(), rbit(), o, "decode");

    case (op)
      4'd0: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b111;
        add_step(op, rbit(), rbit(), o, "r_exec");
        o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.retired = 1'b1;
        add_step(op, rbit(), rbit(), o, "r_wb");
      end
      4'd1, 4'd2, 4'd3: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        o.alu_op = (op == 4'd1) ? 3'b000 : (op == 4'd2) ? 3'b010 : 3'b101;
        add_step(op, rbit(), rbit(), o, "i_exec");
        o = '0; o.reg_write = 1'b1; o.retired = 1'b1;
        add_step(op, rbit(), rbit(), o, "i_wb");
      end
      4'd4, 4'd5: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        add_step(op, rbit(), rbit(), o, "mem_addr");
        for (int i = 0; i <= mw; i++) begin
          o = '0; o.mem_req = 1'b1; o.iord = 1'b1;
          if (op == 4'd4) o.mem_read = 1'b1;
          else begin
            o.mem_write = 1'b1;
            o.retired   = (i == mw);
          end
          add_step(op, rbit(), i == mw, o, (op == 4'd4) ? "mem_read" : "mem_write");
        end
        if (op == 4'd4) begin
          o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.retired = 1'b1;
          add_step(op, rbit(), rbit(), o, "mem_wb");
        end
      end
      4'd6, 4'd7: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b100; o.pc_source = 2'b01;
        o.retired  = 1'b1;
        o.pc_write = (op == 4'd6) ? az : !az;
        add_step(op, az, rbit(), o, "branch");
      end
      4'd8: begin
        o = '0; o.pc_source = 2'b10; o.pc_write = 1'b1; o.retired = 1'b1;
        add_step(op, rbit(), rbit(), o, "jump");
      end
      default: ;
    endcase
  endtask

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic drive_steps(input int n);
    step_t s;
    for (int k = 0; k < n && plan.size() > 0; k++) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      bus.opcode    = s.opcode;
      bus.alu_zero  = s.alu_zero;
      bus.mem_ready = s.mem_ready;
      exp_q.push_back(s);
    end
  endtask

  task automatic expect_zero(input string tag);
    step_t s;
    s.opcode    = bus.opcode;
    s.alu_zero  = bus.alu_zero;
    s.mem_ready = bus.mem_ready;
    s.exp       = '0;
    s.tag       = tag;
    exp_q.push_back(s);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    step_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check(s.tag, sample(), s.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int fw;
    int mw;
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;

    @(posedge clk);
    #1;
    check("reset_outputs", sample(), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_zero("idle");

    // lw abandoned by a reset while waiting in MEM_READ.
    add_instr(4'd4, 0, 3, 1'b0);
    drive_steps(4);
    plan.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_async", sample(), '0);
    expect_zero("in_reset");
    @(posedge clk);
    #1;
    expect_zero("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_zero("idle_after_reset");

    // Directed sequences.
    add_instr(4'd0, 0, 0, 1'b0);  // R-type
    add_instr(4'd4, 2, 3, 1'b0);  // lw, 2 fetch waits, 3 read waits
    add_instr(4'd6, 0, 0, 1'b1);  // beq taken
    add_instr(4'd6, 0, 0, 1'b0);  // beq not taken
    add_instr(4'd7, 0, 0, 1'b0);  // bne taken
    add_instr(4'd2, 0, 0, 1'b0);  // andi
    add_instr(4'd3, 0, 0, 1'b0);  // ori
    add_instr(4'd15, 0, 0, 1'b0); // illegal
    add_instr(4'd8, 0, 0, 1'b0);  // j
    add_instr(4'd5, 1, 2, 1'b0);  // sw with waits
    add_instr(4'd1, 0, 0, 1'b0);  // addi
    add_instr(4'd9, 1, 0, 1'b0);  // first illegal encoding
    drive_steps(plan.size());

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      add_instr(4'($urandom_range(0, 15)), fw, mw, rbit());
      drive_steps(plan.size());
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check_int("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
